// File: rtl/firebird7_in_gate1_tessent_pkg.sv
// Shared definitions for the gate1 IJTAG override logic: default mux width,
// field positions inside the TDR word, and the packed {data, sel} word type.
package firebird7_in_gate1_tessent_pkg;

  // Default override width; matches the gate1 data mux.
  localparam int WIDTH_DEFAULT = 19;

  // Field positions inside the TDR word (shift stage and update stage alike).
  localparam int TDR_SEL_BIT  = 0;
  localparam int TDR_DATA_LSB = 1;

  // Packed TDR word: select in bit 0, data above it.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] data;
    logic                     sel;
  } tdr_word_t;

  // Build a TDR word from its two fields.
  function automatic tdr_word_t tdr_pack(input logic [WIDTH_DEFAULT-1:0] data,
                                         input logic sel);
    tdr_word_t w;
    w.data = data;
    w.sel  = sel;
    return w;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// IJTAG test data register driving the override side of the gate1 data mux.
// A WIDTH+1 bit shift stage (select in bit 0, data above) is loaded serially
// or captures the mux output; an update stage holds the value presented to
// the mux so its outputs only move on update edges.
module firebird7_in_gate1_tessent_tdr_w19
  import firebird7_in_gate1_tessent_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select_out
);

  logic [WIDTH:0]   sr_reg;
  logic [WIDTH-1:0] upd_data_reg;
  logic             upd_sel_reg;

  // Enables only count while this TDR is on the active scan path; capture
  // takes priority over shift when both are requested.
  logic capture_en;
  logic shift_en;
  logic update_en;

  assign capture_en = ijtag_sel & ijtag_ce;
  assign shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign update_en  = ijtag_sel & ijtag_ue;

  // Shift stage: capture the observed mux output plus current select, or
  // shift LSB-first with scan-in entering at the MSB.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_reg <= {RESET_DATA, 1'b0};
    end else if (capture_en) begin
      sr_reg <= {capture_data_in, upd_sel_reg};
    end else if (shift_en) begin
      sr_reg <= {ijtag_si, sr_reg[WIDTH:1]};
    end
  end

  // Update stage: copy the pre-edge shift stage to the mux-facing registers;
  // reset drops the select so the mux falls back to functional data.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_data_reg <= RESET_DATA;
      upd_sel_reg  <= 1'b0;
    end else if (update_en) begin
      upd_data_reg <= sr_reg[WIDTH:TDR_DATA_LSB];
      upd_sel_reg  <= sr_reg[TDR_SEL_BIT];
    end
  end

  // Outputs come straight from registers; scan-out is ungated here because
  // the upstream SIB/mux decides whether it is on the path.
  assign ijtag_so         = sr_reg[TDR_SEL_BIT];
  assign ijtag_data_out   = upd_data_reg;
  assign ijtag_select_out = upd_sel_reg;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv
// Self-checking bench for the gate1 override TDR: a bit-queue model of the
// scan chain plus a model update stage, compared every cycle, with literal
// checks on the directed scenarios.
module tb_firebird7_in_gate1_tessent_tdr_w19;
  import firebird7_in_gate1_tessent_pkg::*;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel, ce, se, ue, si;
  logic         so;
  logic [W-1:0] cdi;
  logic [W-1:0] dout;
  logic         dsel;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: chain as a bit queue, element 0 is the bit on scan-out.
  bit           mq[$];
  logic [W-1:0] m_data;
  logic         m_sel;

  firebird7_in_gate1_tessent_tdr_w19 dut (
    .ijtag_tck        (clk),
    .ijtag_reset      (rst_n),
    .ijtag_sel        (sel),
    .ijtag_ce         (ce),
    .ijtag_se         (se),
    .ijtag_ue         (ue),
    .ijtag_si         (si),
    .ijtag_so         (so),
    .capture_data_in  (cdi),
    .ijtag_data_out   (dout),
    .ijtag_select_out (dsel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i <= W; i++) mq.push_back(1'b0);
    m_data = '0;
    m_sel  = 1'b0;
  endtask

  // One clock edge of the model, using the inputs as they stand at the edge.
  task automatic model_edge();
    bit old[$];
    if (!rst_n) return;
    if (!sel) return;
    old = mq;
    if (ce) begin
      mq.delete();
      mq.push_back(m_sel);
      for (int k = 0; k < W; k++) mq.push_back(cdi[k]);
    end else if (se) begin
      void'(mq.pop_front());
      mq.push_back(si);
    end
    if (ue) begin
      m_sel = old[0];
      for (int k = 0; k < W; k++) m_data[k] = old[k+1];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
  endtask

  // Shift a full word in, select bit first, data LSB next.
  task automatic shift_word(input logic [W-1:0] d, input logic s);
    tdr_word_t w;
    logic [W:0] bits;
    w = tdr_pack(d, s);
    bits = w;
    for (int i = 0; i <= W; i++) begin
      sel = 1'b1; ce = 1'b0; se = 1'b1; ue = 1'b0; si = bits[i];
      cycle();
    end
    idle();
  endtask

  task automatic pulse_ue();
    sel = 1'b1; ue = 1'b1; ce = 1'b0; se = 1'b0;
    cycle();
    idle();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("so", 32'(so), 32'(mq[0]));
      chk("data_out", 32'(dout), 32'(m_data));
      chk("select_out", 32'(dsel), 32'(m_sel));
    end
  end

  initial begin
    logic [W:0]   stream;
    logic [W-1:0] hold_d, rnd_d;
    logic         hold_s, hold_so, rnd_s;

    rst_n = 1'b0; idle(); cdi = '0;
    model_reset();
    chk_en = 1'b1;

    // Reset held with enables toggling.
    for (int i = 0; i < 6; i++) begin
      sel = 1'($urandom); ce = 1'($urandom); se = 1'($urandom);
      ue = 1'($urandom); si = 1'($urandom); cdi = W'($urandom);
      cycle();
    end
    chk("rst_data", 32'(dout), 32'h0);
    chk("rst_sel", 32'(dsel), 32'h0);
    chk("rst_so", 32'(so), 32'h0);
    rst_n = 1'b1; idle();
    cycle();

    // Load 5A5A5 with select set.
    shift_word(19'h5A5A5, 1'b1);
    chk("load_hold_data", 32'(dout), 32'h0);
    chk("load_hold_sel", 32'(dsel), 32'h0);
    pulse_ue();
    chk("load_data", 32'(dout), 32'h5A5A5);
    chk("load_sel", 32'(dsel), 32'h1);

    // Readback: capture 7FFF0 and shift it out.
    cdi = 19'h7FFF0; ce = 1'b1;
    cycle();
    idle();
    stream = {19'h7FFF0, 1'b1};
    chk("rb_bit0", 32'(so), 32'(stream[0]));
    for (int i = 1; i <= W; i++) begin
      se = 1'b1; si = 1'($urandom);
      cycle();
      chk($sformatf("rb_bit%0d", i), 32'(so), 32'(stream[i]));
    end
    idle();

    // Deselected: nothing moves.
    hold_so = so; hold_d = dout; hold_s = dsel;
    for (int i = 0; i < 30; i++) begin
      sel = 1'b0; se = 1'b1; ue = 1'b1; ce = 1'($urandom);
      si = 1'($urandom); cdi = W'($urandom);
      cycle();
    end
    idle();
    chk("desel_data", 32'(dout), 32'h5A5A5);
    chk("desel_sel", 32'(dsel), 32'h1);
    chk("desel_so", 32'(so), 32'(hold_so));
    chk("desel_hold_d", 32'(dout), 32'(hold_d));
    chk("desel_hold_s", 32'(dsel), 32'(hold_s));

    // Capture plus shift: capture only, so scan-out shows the select.
    cdi = 19'h0000F; ce = 1'b1; se = 1'b1; si = 1'b0;
    cycle();
    idle();
    chk("ce_se_so", 32'(so), 32'h1);
    se = 1'b1;
    cycle();
    idle();
    chk("ce_se_bit1", 32'(so), 32'h1);

    // Shift plus update: update takes the pre-shift chain.
    shift_word(19'h12345, 1'b0);
    se = 1'b1; ue = 1'b1; si = 1'b1;
    cycle();
    idle();
    chk("se_ue_data", 32'(dout), 32'h12345);
    chk("se_ue_sel", 32'(dsel), 32'h0);
    chk("se_ue_so", 32'(so), 32'h1);

    // Reset after seven shift bits.
    for (int i = 0; i < 7; i++) begin
      se = 1'b1; si = 1'($urandom);
      cycle();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_data", 32'(dout), 32'h0);
    chk("mid_rst_sel", 32'(dsel), 32'h0);
    chk("mid_rst_so", 32'(so), 32'h0);
    for (int i = 0; i < 3; i++) begin
      sel = 1'($urandom); se = 1'($urandom); ue = 1'($urandom);
      ce = 1'($urandom); si = 1'($urandom);
      cycle();
    end
    rst_n = 1'b1; idle();
    cycle();
    rnd_d = W'($urandom); rnd_s = 1'b1;
    shift_word(rnd_d, rnd_s);
    pulse_ue();
    chk("post_rst_data", 32'(dout), 32'(rnd_d));
    chk("post_rst_sel", 32'(dsel), 32'(rnd_s));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = ($urandom_range(0, 7) != 0);
      ce  = ($urandom_range(0, 9) == 0);
      se  = ($urandom_range(0, 3) != 0);
      ue  = ($urandom_range(0, 9) == 0);
      si  = 1'($urandom);
      cdi = W'($urandom);
      cycle();
    end
    idle();
    cycle();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
